// File: rtl/mealy_decoder.sv
// Receive-side decoder for the 4-state serial Mealy encoder: recovers data bits
// from the encoded stream and packs them LSB-first into WIDTH-bit words.
module mealy_decoder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             y_valid,
    input  logic             y,
    output logic             x_bit,
    output logic             x_bit_valid,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun,
    output logic [1:0]       state
);

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic             x_bit_q, x_bit_d;
    logic             x_bit_valid_q, x_bit_valid_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             word_valid_q, word_valid_d;
    logic             overrun_q, overrun_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;

    logic [1:0]       state_eff;
    logic [CW-1:0]    count_eff;
    logic [WIDTH-1:0] shift_eff;
    logic [WIDTH-1:0] shift_new;
    logic             x_dec;
    logic [1:0]       state_next;

    always_comb begin
        // sync restarts the frame for the bit presented in this same cycle
        state_eff = sync ? S0 : state_q;
        count_eff = sync ? '0 : count_q;
        shift_eff = sync ? '0 : shift_q;

        x_dec = ((state_eff == S0) || (state_eff == S3)) ? y : ~y;

        state_next = state_eff;
        case (state_eff)
            S0: state_next = x_dec ? S0 : S1;
            S1: state_next = x_dec ? S3 : S2;
            S2: state_next = x_dec ? S1 : S0;
            S3: state_next = x_dec ? S2 : S3;
            default: state_next = S0;
        endcase

        shift_new = shift_eff;
        shift_new[count_eff] = x_dec;

        state_d       = state_eff;
        count_d       = count_eff;
        shift_d       = shift_eff;
        x_bit_d       = x_bit_q;
        x_bit_valid_d = 1'b0;
        word_d        = word_q;
        word_valid_d  = word_valid_q & ~word_ready;
        overrun_d     = overrun_q;

        if (y_valid) begin
            state_d       = state_next;
            x_bit_d       = x_dec;
            x_bit_valid_d = 1'b1;
            if (count_eff == LAST) begin
                count_d = '0;
                shift_d = '0;
                // an unconsumed word always wins; the new one is dropped
                if (word_valid_q && !word_ready) begin
                    overrun_d = 1'b1;
                end else begin
                    word_d       = shift_new;
                    word_valid_d = 1'b1;
                end
            end else begin
                count_d = count_eff + CW'(1);
                shift_d = shift_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S0;
            x_bit_q       <= 1'b0;
            x_bit_valid_q <= 1'b0;
            word_q        <= '0;
            word_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
            count_q       <= '0;
            shift_q       <= '0;
        end else begin
            state_q       <= state_d;
            x_bit_q       <= x_bit_d;
            x_bit_valid_q <= x_bit_valid_d;
            word_q        <= word_d;
            word_valid_q  <= word_valid_d;
            overrun_q     <= overrun_d;
            count_q       <= count_d;
            shift_q       <= shift_d;
        end
    end

    assign x_bit       = x_bit_q;
    assign x_bit_valid = x_bit_valid_q;
    assign word        = word_q;
    assign word_valid  = word_valid_q;
    assign overrun     = overrun_q;
    assign state       = state_q;

endmodule
